// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
// The block geometry must match the memory controller.
package mem_arb_pkg;

  localparam int unsigned BLOCK_WIDTH = 2;
  localparam int unsigned BLOCK_BITS  = 32 << BLOCK_WIDTH;
  localparam int unsigned BLK_OFF_W   = 4;
  localparam int unsigned GNT_N       = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_P = 2'd2,
    ST_BUSY_L = 2'd3
  } state_e;

  // Values double as bit positions in the eligible/grant vectors
  typedef enum logic [1:0] {
    GNT_LSB    = 2'd0,
    GNT_ICACHE = 2'd1,
    GNT_PF     = 2'd2
  } gnt_e;

  function automatic logic [31:0] blk_align(input logic [31:0] addr);
    return {addr[31:BLK_OFF_W], BLK_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: LSB and ICache alternate on contention,
// prefetch only wins when neither of them wants the controller.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [GNT_N-1:0] eligible,
  input  gnt_e             last_grant,
  output logic [GNT_N-1:0] grant_c
);

  always_comb begin
    grant_c = '0;
    if (eligible[GNT_LSB] && eligible[GNT_ICACHE]) begin
      if (last_grant == GNT_LSB) grant_c[GNT_ICACHE] = 1'b1;
      else                       grant_c[GNT_LSB]    = 1'b1;
    end else if (eligible[GNT_LSB]) begin
      grant_c[GNT_LSB] = 1'b1;
    end else if (eligible[GNT_ICACHE]) begin
      grant_c[GNT_ICACHE] = 1'b1;
    end else if (eligible[GNT_PF]) begin
      grant_c[GNT_PF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates ICache, prefetcher and LSB onto the single-port memory controller,
// merging demand fetches into matching prefetches and discarding flushed fetches.
module mem_request_arbiter
  import mem_arb_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  icache_req,
  input  logic [31:0]           icache_addr,
  output logic                  icache_resp_en,
  input  logic                  pf_req,
  input  logic [31:0]           pf_addr,
  output logic                  pf_resp_en,
  output logic [BLOCK_BITS-1:0] blk_resp_data,
  input  logic                  lsb_req,
  input  logic                  lsb_type,
  input  logic [31:0]           lsb_addr,
  input  logic [1:0]            lsb_width,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_resp_en,
  output logic [31:0]           lsb_resp_data,
  output logic                  mc_icache_query_en,
  output logic [31:0]           mc_head_addr,
  input  logic                  mc_icache_block_en,
  input  logic [BLOCK_BITS-1:0] mc_icache_block_data,
  output logic                  mc_lsb_query_en,
  output logic                  mc_lsb_query_type,
  output logic [31:0]           mc_lsb_query_addr,
  output logic [1:0]            mc_lsb_data_width,
  output logic [31:0]           mc_lsb_query_data,
  input  logic                  mc_lsb_result_en,
  input  logic [31:0]           mc_lsb_result_data
);

  state_e                state, state_d;
  gnt_e                  last_grant, last_grant_d;
  logic                  merge, merge_d, drop, drop_d;
  logic [GNT_N-1:0]      eligible, grant_c;
  logic                  merge_hit;
  logic                  icache_resp_en_d, pf_resp_en_d, lsb_resp_en_d;
  logic [BLOCK_BITS-1:0] blk_resp_data_d;
  logic [31:0]           lsb_resp_data_d;
  logic                  mc_icache_query_en_d, mc_lsb_query_en_d;
  logic [31:0]           mc_head_addr_d;
  logic                  mc_lsb_query_type_d;
  logic [31:0]           mc_lsb_query_addr_d, mc_lsb_query_data_d;
  logic [1:0]            mc_lsb_data_width_d;

  // A requester is masked while its own response is on the bus
  assign eligible[GNT_LSB]    = lsb_req & ~lsb_resp_en;
  assign eligible[GNT_ICACHE] = icache_req & ~icache_resp_en & ~flush_in;
  assign eligible[GNT_PF]     = pf_req & ~pf_resp_en & ~flush_in;

  // mc_head_addr still holds the in-flight prefetch block while in BUSY_P
  assign merge_hit = eligible[GNT_ICACHE] &&
                     (icache_addr[31:BLK_OFF_W] == mc_head_addr[31:BLK_OFF_W]);

  mem_arb_pick u_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant_c    (grant_c)
  );

  always_comb begin
    state_d              = state;
    last_grant_d         = last_grant;
    merge_d              = merge;
    drop_d               = drop;
    icache_resp_en_d     = 1'b0;
    pf_resp_en_d         = 1'b0;
    lsb_resp_en_d        = 1'b0;
    mc_icache_query_en_d = 1'b0;
    mc_lsb_query_en_d    = 1'b0;
    blk_resp_data_d      = blk_resp_data;
    lsb_resp_data_d      = lsb_resp_data;
    mc_head_addr_d       = mc_head_addr;
    mc_lsb_query_type_d  = mc_lsb_query_type;
    mc_lsb_query_addr_d  = mc_lsb_query_addr;
    mc_lsb_data_width_d  = mc_lsb_data_width;
    mc_lsb_query_data_d  = mc_lsb_query_data;

    case (state)
      ST_IDLE: begin
        if (grant_c[GNT_LSB]) begin
          state_d             = ST_BUSY_L;
          last_grant_d        = GNT_LSB;
          mc_lsb_query_en_d   = 1'b1;
          mc_lsb_query_type_d = lsb_type;
          mc_lsb_query_addr_d = lsb_addr;
          mc_lsb_data_width_d = lsb_width;
          mc_lsb_query_data_d = lsb_wdata;
        end else if (grant_c[GNT_ICACHE]) begin
          state_d              = ST_BUSY_I;
          last_grant_d         = GNT_ICACHE;
          mc_icache_query_en_d = 1'b1;
          mc_head_addr_d       = blk_align(icache_addr);
        end else if (grant_c[GNT_PF]) begin
          state_d              = ST_BUSY_P;
          mc_icache_query_en_d = 1'b1;
          mc_head_addr_d       = blk_align(pf_addr);
        end
      end

      ST_BUSY_I, ST_BUSY_P: begin
        if (state == ST_BUSY_P && merge_hit) merge_d = 1'b1;
        if (flush_in) drop_d = 1'b1;
        if (mc_icache_block_en) begin
          state_d = ST_IDLE;
          merge_d = 1'b0;
          drop_d  = 1'b0;
          // A flushed fetch completes silently at the controller
          if (!drop && !flush_in) begin
            blk_resp_data_d = mc_icache_block_data;
            if (state == ST_BUSY_I) begin
              icache_resp_en_d = 1'b1;
            end else begin
              pf_resp_en_d     = 1'b1;
              icache_resp_en_d = merge | merge_hit;
            end
          end
        end
      end

      ST_BUSY_L: begin
        if (mc_lsb_result_en) begin
          state_d         = ST_IDLE;
          lsb_resp_en_d   = 1'b1;
          lsb_resp_data_d = mc_lsb_result_data;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // rdy_in low freezes state and every registered output
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state              <= ST_IDLE;
      last_grant         <= GNT_LSB;
      merge              <= 1'b0;
      drop               <= 1'b0;
      icache_resp_en     <= 1'b0;
      pf_resp_en         <= 1'b0;
      lsb_resp_en        <= 1'b0;
      blk_resp_data      <= '0;
      lsb_resp_data      <= '0;
      mc_icache_query_en <= 1'b0;
      mc_head_addr       <= '0;
      mc_lsb_query_en    <= 1'b0;
      mc_lsb_query_type  <= 1'b0;
      mc_lsb_query_addr  <= '0;
      mc_lsb_data_width  <= '0;
      mc_lsb_query_data  <= '0;
    end else if (rdy_in) begin
      state              <= state_d;
      last_grant         <= last_grant_d;
      merge              <= merge_d;
      drop               <= drop_d;
      icache_resp_en     <= icache_resp_en_d;
      pf_resp_en         <= pf_resp_en_d;
      lsb_resp_en        <= lsb_resp_en_d;
      blk_resp_data      <= blk_resp_data_d;
      lsb_resp_data      <= lsb_resp_data_d;
      mc_icache_query_en <= mc_icache_query_en_d;
      mc_head_addr       <= mc_head_addr_d;
      mc_lsb_query_en    <= mc_lsb_query_en_d;
      mc_lsb_query_type  <= mc_lsb_query_type_d;
      mc_lsb_query_addr  <= mc_lsb_query_addr_d;
      mc_lsb_data_width  <= mc_lsb_data_width_d;
      mc_lsb_query_data  <= mc_lsb_query_data_d;
    end
  end

endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
Sits between the three memory requesters and the single-port Memory_Controller: ICache demand fetch, the next-block instruction prefetcher, and the LSB. It presents at most one query to the controller at a time and routes each completion back to its owner. It also merges a demand fetch into an in-flight prefetch of the same block, and discards instruction-side responses after a pipeline flush.

Parameters:
BLOCK_WIDTH, 2, log2 words per block; block is 4 words = 16 bytes = 128 bits; fixed, must match Memory_Controller.
BLOCK_BITS, 32<<BLOCK_WIDTH, width of the block data buses.

Ports:
clk_in  in  1  system clock, all logic on rising edge
rst_in  in  1  synchronous active-low reset (0 = reset), sampled on clk_in
rdy_in  in  1  global ready; when 0, all state and outputs hold
flush_in  in  1  mispredict flush pulse; cancels ICache and prefetch work
icache_req  in  1  demand fetch request, held until icache_resp_en
icache_addr  in  32  fetch address; bits [3:0] ignored
icache_resp_en  out  1  one-cycle pulse: blk_resp_data valid for ICache
pf_req  in  1  prefetch request, held until pf_resp_en or flush
pf_addr  in  32  prefetch block address; bits [3:0] ignored
pf_resp_en  out  1  one-cycle pulse: blk_resp_data valid for prefetcher
blk_resp_data  out  BLOCK_BITS  registered block data, shared by ICache and prefetcher
lsb_req  in  1  LSB request, held until lsb_resp_en
lsb_type  in  1  0 read, 1 write
lsb_addr  in  32  byte address, including 0x30000/0x30004
lsb_width  in  2  0 byte, 1 half, 2 word
lsb_wdata  in  32  store data
lsb_resp_en  out  1  one-cycle pulse: load data valid or store done
lsb_resp_data  out  32  registered load data
mc_icache_query_en  out  1  one-cycle query pulse to controller
mc_head_addr  out  32  block-aligned address, {addr[31:4],4'b0}
mc_icache_block_en  in  1  controller block-done pulse
mc_icache_block_data  in  BLOCK_BITS  controller block data
mc_lsb_query_en  out  1  one-cycle query pulse to controller
mc_lsb_query_type  out  1  copy of lsb_type
mc_lsb_query_addr  out  32  copy of lsb_addr
mc_lsb_data_width  out  2  copy of lsb_width
mc_lsb_query_data  out  32  copy of lsb_wdata
mc_lsb_result_en  in  1  controller LSB-done pulse
mc_lsb_result_data  in  32  controller load data

Behaviour:
- Reset (rst_in==0 at an edge): state IDLE, last_grant=LSB, merge=0, drop=0. All outputs 0, including data buses. The controller is reset by the same system reset, so an in-flight transaction is abandoned silently.
- States:
  - IDLE: pick a requester; on a grant, register its request fields and pulse the matching mc_*_query_en for exactly one cycle (the cycle after the grant decision). The grant moves the state to BUSY_I, BUSY_P or BUSY_L.
  - BUSY_*: the query_en output is 0 and no grants are made; leave BUSY_* only on the matching mc done pulse.
- Eligibility in IDLE:
  - A requester is masked in any cycle where its own resp_en is 1, so a held request is not re-granted.
  - icache_req and pf_req are masked when flush_in==1.
- Priority in IDLE:
  - LSB vs ICache, both eligible: grant the one != last_grant, then update last_grant.
  - A single eligible one of the two wins outright.
  - Prefetch is granted only when neither LSB nor ICache is eligible; it may starve.
- Merge: in BUSY_P, if icache_req is eligible and icache_addr[31:4]==latched pf address[31:4], set merge=1. On completion both icache_resp_en and pf_resp_en pulse in the same cycle.
- Flush:
  - flush_in in BUSY_I/BUSY_P sets drop=1.
  - A completion with drop==1, or coinciding with flush_in, emits no resp pulse and clears drop and merge.
  - BUSY_L is unaffected by flush.
- Completion:
  - The done pulse at cycle t registers the data into blk_resp_data or lsb_resp_data, pulses resp_en at t+1, and returns to IDLE at t+1.
  - The earliest next mc query pulse is t+2, when the controller is already IDLE.
- Latencies: request seen in IDLE at cycle t gives the query pulse at t+1; response at (controller done)+1.
- rdy_in==0: everything frozen. Resp/query pulses are held (not repeated, not lost) until rdy_in returns.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE, BUSY_I, BUSY_P, BUSY_L), grant ids (GNT_LSB, GNT_ICACHE, GNT_PF), BLOCK_WIDTH, BLOCK_BITS, block-offset width 4.
- Sub-module mem_arb_pick: combinational picker taking eligible[2:0] and last_grant, producing a one-hot grant.

Test Plan:
- ICache-only fetch at addr 0x1234 -> mc_head_addr=0x1230, one query pulse, icache_resp_en one cycle after mc_icache_block_en, data passed through exactly.
- lsb_req and icache_req both raised at the same cycle from reset -> ICache granted first, LSB second, then alternation over 4 back-to-back rounds.
- Prefetch of 0x2000 in flight, icache_req at 0x2008 -> no second mc query; icache_resp_en and pf_resp_en pulse together with the same data.
- flush_in during BUSY_I, and separately on the same cycle as mc_icache_block_en -> no icache_resp_en. The next LSB request issues normally.
- Held request after response: keep lsb_req high for 1 cycle after lsb_resp_en -> exactly one mc_lsb_query_en.
- rst_in=0 mid BUSY_L, and rdy_in=0 during a done pulse -> all outputs 0 after reset; with rdy_in low, resp is delayed, not lost.
